fifo_ptr_ctrl: RTL and testbench

Parametrised pointer and status controller for the FIFO. It generates both the write and read addresses for any memory depth, including non-power-of-two depths, by wrapping at `MEMORY_DEPTH-1` and tracking a lap bit. It also produces full/empty, almost-full/almost-empty, an occupancy count, and overflow/underflow error pulses. It sits between the FIFO request interface and the dual-port storage array, and drives that array's write/read enables and addresses.

---
 rtl/fifo_ptr_ctrl_if.sv | 34 +++
 rtl/fifo_ptr_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/status bundle between the FIFO front end and the pointer controller.
// The master side drives requests; the slave side (the controller) drives strobes, addresses and status.
interface fifo_ptr_ctrl_if #(
    parameter int MEMORY_DEPTH = 4
) ();
    localparam int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH);

    logic                         wr_req;
    logic                         rd_req;
    logic                         flush;
    logic                         w_en;
    logic                         r_en;
    logic [FIFO_ADDRESS_SIZE-1:0] w_addr;
    logic [FIFO_ADDRESS_SIZE-1:0] r_addr;
    logic [FIFO_ADDRESS_SIZE:0]   count;
    logic                         full;
    logic                         empty;
    logic                         almost_full;
    logic                         almost_empty;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output wr_req, rd_req, flush,
        input  w_en, r_en, w_addr, r_addr, count,
        input  full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req, flush,
        output w_en, r_en, w_addr, r_addr, count,
        output full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/status controller: lap-bit pointers that wrap at MEMORY_DEPTH-1 (any depth),
// occupancy count, full/empty and almost flags, and registered overflow/underflow pulses.
module fifo_ptr_ctrl #(
    parameter int MEMORY_DEPTH      = 4,
    parameter int FIFO_ADDRESS_SIZE = $clog2(MEMORY_DEPTH),
    parameter int ALMOST_FULL_LVL   = MEMORY_DEPTH - 1,
    parameter int ALMOST_EMPTY_LVL  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_ptr_ctrl_if.slave bus
);
    localparam int CW = FIFO_ADDRESS_SIZE + 1;
    localparam logic [FIFO_ADDRESS_SIZE-1:0] LAST_ADDR = FIFO_ADDRESS_SIZE'(MEMORY_DEPTH - 1);
    localparam logic [CW-1:0] AF_LVL = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] AE_LVL = CW'(ALMOST_EMPTY_LVL);

    logic [FIFO_ADDRESS_SIZE-1:0] w_addr_reg, w_addr_next;
    logic [FIFO_ADDRESS_SIZE-1:0] r_addr_reg, r_addr_next;
    logic                         w_lap_reg, w_lap_next;
    logic                         r_lap_reg, r_lap_next;
    logic [CW-1:0]                count_reg, count_next;
    logic                         overflow_reg, overflow_next;
    logic                         underflow_reg, underflow_next;

    logic full;
    logic empty;
    logic w_en;
    logic r_en;

    // Equal addresses are disambiguated by the lap bits: same lap = empty, different lap = full.
    assign empty = (w_addr_reg == r_addr_reg) && (w_lap_reg == r_lap_reg);
    assign full  = (w_addr_reg == r_addr_reg) && (w_lap_reg != r_lap_reg);

    assign w_en = bus.wr_req & ~full  & ~bus.flush;
    assign r_en = bus.rd_req & ~empty & ~bus.flush;

    always_comb begin
        w_addr_next    = w_addr_reg;
        r_addr_next    = r_addr_reg;
        w_lap_next     = w_lap_reg;
        r_lap_next     = r_lap_reg;
        count_next     = count_reg;
        overflow_next  = bus.wr_req & full  & ~bus.flush;
        underflow_next = bus.rd_req & empty & ~bus.flush;

        if (bus.flush) begin
            w_addr_next = '0;
            r_addr_next = '0;
            w_lap_next  = 1'b0;
            r_lap_next  = 1'b0;
            count_next  = '0;
        end else begin
            if (w_en) begin
                if (w_addr_reg == LAST_ADDR) begin
                    w_addr_next = '0;
                    w_lap_next  = ~w_lap_reg;
                end else begin
                    w_addr_next = w_addr_reg + 1'b1;
                end
            end

            if (r_en) begin
                if (r_addr_reg == LAST_ADDR) begin
                    r_addr_next = '0;
                    r_lap_next  = ~r_lap_reg;
                end else begin
                    r_addr_next = r_addr_reg + 1'b1;
                end
            end

            // A simultaneous accepted read and write leaves occupancy unchanged.
            case ({w_en, r_en})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr_reg    <= '0;
            r_addr_reg    <= '0;
            w_lap_reg     <= 1'b0;
            r_lap_reg     <= 1'b0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            w_addr_reg    <= w_addr_next;
            r_addr_reg    <= r_addr_next;
            w_lap_reg     <= w_lap_next;
            r_lap_reg     <= r_lap_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.w_en         = w_en;
    assign bus.r_en         = r_en;
    assign bus.w_addr       = w_addr_reg;
    assign bus.r_addr       = r_addr_reg;
    assign bus.count        = count_reg;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_reg >= AF_LVL);
    assign bus.almost_empty = (count_reg <= AE_LVL);
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench: a depth-5 instance for directed fill/drain/wrap/flush steps and a
// depth-4 instance for a random run, both against a count-based reference model.
module tb_fifo_ptr_ctrl;
    typedef struct packed {
        int wa;
        int wl;
        int ra;
        int rl;
        int cnt;
        int ovf;
        int unf;
    } mstate_t;

    typedef struct packed {
        int we;
        int re;
        int wa;
        int ra;
        int cnt;
        int full;
        int empty;
        int af;
        int ae;
        int ovf;
        int unf;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int failed = 0;
    mstate_t m5;
    mstate_t m4;
    mstate_t exp_q[$];

    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.MEMORY_DEPTH(5)) bus5 ();
    fifo_ptr_ctrl_if #(.MEMORY_DEPTH(4)) bus4 ();

    fifo_ptr_ctrl #(.MEMORY_DEPTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));
    fifo_ptr_ctrl #(.MEMORY_DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic mstate_t model_next(mstate_t s, int depth, bit wr, bit rd, bit fl);
        mstate_t n;
        bit we, re;
        we = wr && (s.cnt != depth) && !fl;
        re = rd && (s.cnt != 0) && !fl;
        n = s;
        n.ovf = (wr && (s.cnt == depth) && !fl) ? 1 : 0;
        n.unf = (rd && (s.cnt == 0) && !fl) ? 1 : 0;
        if (fl) begin
            n.wa = 0; n.wl = 0; n.ra = 0; n.rl = 0; n.cnt = 0;
        end else begin
            if (we) begin
                if (s.wa == depth - 1) begin n.wa = 0; n.wl = 1 - s.wl; end
                else n.wa = s.wa + 1;
            end
            if (re) begin
                if (s.ra == depth - 1) begin n.ra = 0; n.rl = 1 - s.rl; end
                else n.ra = s.ra + 1;
            end
            n.cnt = s.cnt + (we ? 1 : 0) - (re ? 1 : 0);
        end
        return n;
    endfunction

    task automatic observe(input int sel, output obs_t o);
        if (sel == 5) begin
            o.we = int'(bus5.w_en);   o.re = int'(bus5.r_en);
            o.wa = int'(bus5.w_addr); o.ra = int'(bus5.r_addr);
            o.cnt = int'(bus5.count); o.full = int'(bus5.full);
            o.empty = int'(bus5.empty); o.af = int'(bus5.almost_full);
            o.ae = int'(bus5.almost_empty);
            o.ovf = int'(bus5.overflow); o.unf = int'(bus5.underflow);
        end else begin
            o.we = int'(bus4.w_en);   o.re = int'(bus4.r_en);
            o.wa = int'(bus4.w_addr); o.ra = int'(bus4.r_addr);
            o.cnt = int'(bus4.count); o.full = int'(bus4.full);
            o.empty = int'(bus4.empty); o.af = int'(bus4.almost_full);
            o.ae = int'(bus4.almost_empty);
            o.ovf = int'(bus4.overflow); o.unf = int'(bus4.underflow);
        end
    endtask

    task automatic drive(input int sel, input bit wr, input bit rd, input bit fl);
        bus5.wr_req = (sel == 5) ? wr : 1'b0;
        bus5.rd_req = (sel == 5) ? rd : 1'b0;
        bus5.flush  = (sel == 5) ? fl : 1'b0;
        bus4.wr_req = (sel == 4) ? wr : 1'b0;
        bus4.rd_req = (sel == 4) ? rd : 1'b0;
        bus4.flush  = (sel == 4) ? fl : 1'b0;
    endtask

    // One clock of stimulus: check strobes/addresses before the edge, state after it.
    task automatic step(input int sel, input bit wr, input bit rd, input bit fl, input string tag);
        mstate_t cur, exp;
        obs_t o;
        int depth;
        string t;
        depth = sel;
        cur = (sel == 5) ? m5 : m4;
        t = $sformatf("d%0d_%s", sel, tag);
        drive(sel, wr, rd, fl);
        #1;
        observe(sel, o);
        check({t, "_w_en"}, o.we, (wr && cur.cnt != depth && !fl) ? 1 : 0);
        check({t, "_r_en"}, o.re, (rd && cur.cnt != 0 && !fl) ? 1 : 0);
        check({t, "_w_addr"}, o.wa, cur.wa);
        check({t, "_r_addr"}, o.ra, cur.ra);
        exp_q.push_back(model_next(cur, depth, wr, rd, fl));
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        observe(sel, o);
        check({t, "_count"}, o.cnt, exp.cnt);
        check({t, "_full"}, o.full, (exp.cnt == depth) ? 1 : 0);
        check({t, "_empty"}, o.empty, (exp.cnt == 0) ? 1 : 0);
        check({t, "_afull"}, o.af, (exp.cnt >= depth - 1) ? 1 : 0);
        check({t, "_aempty"}, o.ae, (exp.cnt <= 1) ? 1 : 0);
        check({t, "_ovf"}, o.ovf, exp.ovf);
        check({t, "_unf"}, o.unf, exp.unf);
        check({t, "_w_addr_nx"}, o.wa, exp.wa);
        check({t, "_r_addr_nx"}, o.ra, exp.ra);
        check({t, "_addr_range"}, (o.wa < depth && o.ra < depth) ? 1 : 0, 1);
        if (sel == 5) m5 = exp; else m4 = exp;
        $display("[TB] %s wr=%0b rd=%0b fl=%0b -> cnt=%0d wa=%0d ra=%0d full=%0d empty=%0d ovf=%0d unf=%0d",
                 t, wr, rd, fl, o.cnt, o.wa, o.ra, o.full, o.empty, o.ovf, o.unf);
        @(negedge clk);
    endtask

    // Reset asserted away from any rising edge must clear both instances at once.
    task automatic do_reset(input string tag);
        obs_t o;
        drive(5, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int s = 4; s <= 5; s++) begin
            observe(s, o);
            check($sformatf("%s_d%0d_count", tag, s), o.cnt, 0);
            check($sformatf("%s_d%0d_empty", tag, s), o.empty, 1);
            check($sformatf("%s_d%0d_full", tag, s), o.full, 0);
            check($sformatf("%s_d%0d_aempty", tag, s), o.ae, 1);
            check($sformatf("%s_d%0d_afull", tag, s), o.af, 0);
            check($sformatf("%s_d%0d_ovf", tag, s), o.ovf, 0);
            check($sformatf("%s_d%0d_unf", tag, s), o.unf, 0);
            check($sformatf("%s_d%0d_addrs", tag, s), o.wa + o.ra, 0);
            check($sformatf("%s_d%0d_strobes", tag, s), o.we + o.re, 0);
        end
        $display("[TB] %s reset asserted", tag);
        m5 = '0;
        m4 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(5, 1'b0, 1'b0, 1'b0);
        #2;
        do_reset("rst0");

        for (int i = 0; i < 5; i++) step(5, 1, 0, 0, "fill");
        step(5, 1, 0, 0, "ovf");
        step(5, 1, 0, 0, "ovf2");
        step(5, 0, 0, 0, "idle");
        for (int i = 0; i < 5; i++) step(5, 0, 1, 0, "drain");
        step(5, 0, 1, 0, "unf");
        step(5, 0, 0, 0, "idle");

        step(5, 1, 0, 0, "w");
        step(5, 1, 0, 0, "w");
        for (int i = 0; i < 10; i++) step(5, 1, 1, 0, "both");

        for (int i = 0; i < 3; i++) step(5, 1, 0, 0, "fill");
        step(5, 1, 1, 0, "both_full");
        step(5, 0, 0, 0, "idle");

        for (int i = 0; i < 4; i++) step(5, 0, 1, 0, "drain");
        step(5, 1, 1, 0, "both_empty");
        step(5, 0, 0, 0, "idle");

        step(5, 1, 0, 0, "w");
        step(5, 1, 0, 0, "w");
        step(5, 1, 0, 1, "flush_wr");
        step(5, 0, 1, 1, "flush_rd");
        step(5, 1, 0, 0, "w");
        step(5, 1, 0, 0, "w");

        for (int i = 0; i < 1000; i++)
            step(4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 40) == 0), "rand");
        for (int i = 0; i < 3; i++) step(4, 1, 0, 0, "w");
        step(5, 1, 0, 0, "w");

        do_reset("rst1");
        step(5, 1, 0, 0, "post_rst");
        step(4, 0, 1, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
